// File: rtl/key_debounce_module.sv
// Debouncer for one active-low push button: 2-flop synchroniser, filter FSM,
// registered level output plus press / release / long-press strobes.
module key_debounce_module #(
    parameter int T10MS = 500_000,
    parameter int T1S   = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_In,
    output logic KEY_State,
    output logic KEY_Press,
    output logic KEY_Release,
    output logic KEY_Long
);

    typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(T10MS - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(T1S - 1);
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(T1S - 2);

    logic [1:0]       sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             key_state_q, key_state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             key_s;

    assign key_s = sync_q[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            lcnt_q      <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], KEY_In};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcnt_q      <= lcnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == FILT_MAX) begin
                    state_d = DOWN;
                    lcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                // lcnt saturates at T1S-1 so the long strobe cannot repeat
                if (key_s) begin
                    state_d = REL_FILT;
                    cnt_d   = '0;
                end else if (lcnt_q != LONG_MAX) begin
                    lcnt_d = lcnt_q + CNT_W'(1);
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    state_d = DOWN;
                end else if (cnt_q == FILT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Long strobe fires on the edge where lcnt reaches T1S-1 (T1S-1 held cycles in DOWN)
    always_comb begin
        key_state_d = (state_d == DOWN) || (state_d == REL_FILT);
        press_d     = (state_q == PRESS_FILT) && (state_d == DOWN);
        release_d   = (state_q == REL_FILT) && (state_d == IDLE);
        long_d      = (state_q == DOWN) && !key_s && (lcnt_q == LONG_PRE);
    end

    assign KEY_State   = key_state_q;
    assign KEY_Press   = press_q;
    assign KEY_Release = release_q;
    assign KEY_Long    = long_q;

endmodule

// File: tb/tb_key_debounce_module.sv
// Scoreboard bench for key_debounce_module: run-length reference model feeds an
// expectation queue drained by a monitor, plus directed latency checks.
module tb_key_debounce_module;

    localparam int T10MS = 4;
    localparam int T1S   = 10;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic KEY_In = 1'b1;
    logic KEY_State, KEY_Press, KEY_Release, KEY_Long;

    key_debounce_module #(.T10MS(T10MS), .T1S(T1S), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .KEY_In(KEY_In),
        .KEY_State(KEY_State), .KEY_Press(KEY_Press),
        .KEY_Release(KEY_Release), .KEY_Long(KEY_Long)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // expected {State, Press, Release, Long} after each edge
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;

    // Model: key_s is KEY_In delayed two samples; level flips once the sampled
    // key has disagreed with it for T10MS+1 consecutive edges.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0;
    int   m_run = 0, m_hold = 0;
    bit   m_fired = 1'b0;

    task automatic cyc(input logic rst, input logic key);
        logic [3:0] e;
        logic p;
        @(negedge CLK);
        RST = rst;
        KEY_In = key;
        e = 4'b0000;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
            m_run = 0; m_hold = 0; m_fired = 1'b0;
        end else begin
            p = !m_s2;
            if (p != m_lvl) begin
                m_run++;
                if (m_run == T10MS + 1) begin
                    m_lvl = p;
                    m_run = 0;
                    if (p) begin
                        e[2] = 1'b1; m_hold = 0; m_fired = 1'b0;
                    end else begin
                        e[1] = 1'b1;
                    end
                end
            end else begin
                // held and not in a release filter window: hold time advances
                if (m_lvl && m_run == 0) begin
                    if (m_hold < T1S - 1) m_hold++;
                    if (m_hold == T1S - 1 && !m_fired) begin
                        e[0] = 1'b1; m_fired = 1'b1;
                    end
                end
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
        e[3] = m_lvl;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK) begin
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if ({KEY_State, KEY_Press, KEY_Release, KEY_Long} !== mon_e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got S/P/R/L=%b want %b", cycle,
                         {KEY_State, KEY_Press, KEY_Release, KEY_Long}, mon_e);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // sel: 0 press, 1 release, 2 long; first = 1-based edge index of first strobe
    task automatic watch(input logic key, input int sel, input int len,
                         output int first, output int cnt);
        logic s;
        first = 0;
        cnt = 0;
        for (int i = 1; i <= len; i++) begin
            cyc(1'b0, key);
            @(posedge CLK);
            #2;
            s = (sel == 0) ? KEY_Press : (sel == 1) ? KEY_Release : KEY_Long;
            if (s) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int f, c, c2, len;
        logic lvl;
        repeat (3) cyc(1'b1, 1'b0);
        @(posedge CLK);
        #2;
        check("reset_outputs", {KEY_State, KEY_Press, KEY_Release, KEY_Long}, 0);

        watch(1'b0, 0, 7, f, c);
        check("press_after_reset_edge", f, 7);
        check("state_after_press", KEY_State, 1);

        watch(1'b0, 2, 20, f, c);
        check("long_delay", f, 9);
        check("long_count", c, 1);

        watch(1'b1, 1, 7, f, c);
        check("release_delay", f, 7);
        check("state_at_release", KEY_State, 0);

        watch(1'b0, 0, 3, f, c);
        watch(1'b1, 0, 2, f, c2);
        check("glitch_no_press", c + c2, 0);
        watch(1'b0, 0, 7, f, c);
        check("press_after_glitch", f, 7);

        cyc(1'b1, 1'b0);
        @(posedge CLK);
        #2;
        check("rst_in_down_state", KEY_State, 0);
        check("rst_in_down_release", KEY_Release, 0);
        watch(1'b0, 0, 7, f, c);
        check("repress_after_rst", f, 7);

        lvl = 1'b0;
        for (int seg = 0; seg < 160; seg++) begin
            if ($urandom_range(0, 99) < 3) begin
                repeat ($urandom_range(1, 2)) cyc(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                lvl = ~lvl;
                len = ($urandom_range(0, 99) < 40) ? $urandom_range(1, 4)
                                                   : $urandom_range(5, 25);
                repeat (len) cyc(1'b0, lvl);
            end
        end
        repeat (40) cyc(1'b0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
